rr_arbiter_4: RTL and testbench
===============================

Name: rr_arbiter_4

Overview:
Four-requester round-robin arbiter that shares one downstream resource (one encoder/datapath slot) among four clients.
- Selects one requester and holds the grant until the requester releases it.
- Presents the winner both as a one-hot grant vector and as a 2-bit encoded index.
- The index uses the same 4:2 encoding as the team's encoder blocks: line 3 -> 2'b11, line 2 -> 2'b10, line 1 -> 2'b01, line 0 -> 2'b00.

Parameters:
HOLD_MAX, 15, maximum BUSY cycles before forced release (used only with RR_ARB_TIMEOUT_EN); legal range 1..(2^CNT_W - 1)
CNT_W, 4, width of the hold counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  4  request lines; req[i]=1 means client i wants the resource
done  input  1  single-cycle release pulse from the current owner
grant  output  4  one-hot grant, registered
grant_idx  output  2  encoded index of the granted line, registered
grant_valid  output  1  1 while any grant is active
timeout  output  1  1-cycle pulse on forced release

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset, asserted asynchronously and effective immediately:
  - Outputs: grant=4'b0000, grant_idx=2'b00, grant_valid=0, timeout=0.
  - Internal: state=IDLE, ptr=2'b00, hold_cnt=0.
  - Reset during BUSY drops the grant in the same cycle; no release bookkeeping occurs.
- ptr is the highest-priority line for the next arbitration. Search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- State IDLE:
  - If req==0, remain in IDLE.
  - Otherwise winner = first set req bit in search order.
  - Next edge: state=BUSY, grant=1<<winner, grant_idx=winner, grant_valid=1, hold_cnt=0.
  - Latency: req sampled at edge N gives grant visible after edge N+1 (one cycle).
  - done is ignored in IDLE.
- State BUSY:
  - grant and grant_idx stay stable for the whole tenure.
  - Changes on non-granted req lines are ignored.
  - Release condition: done==1 OR req[grant_idx]==0 OR a timeout event.
  - On the release edge: grant=0, grant_valid=0, ptr=grant_idx+1 (mod 4; 3 wraps to 0), state=IDLE.
  - At least one IDLE cycle separates consecutive grants; back-to-back grant changes never occur.
- Simultaneous events:
  - done together with a req drop counts as one release.
  - done together with a timeout gives a normal release; timeout stays 0 because done wins.
- No starvation: a requester that holds req is granted within 4 tenures.
- grant is always zero or one-hot. grant_idx equals the encoding of grant whenever grant_valid=1, and holds its last value when grant_valid=0.

Optional Feature:
- Macro: RR_ARB_TIMEOUT_EN.
- Defined:
  - hold_cnt increments once per BUSY cycle.
  - When hold_cnt==HOLD_MAX-1 and no other release condition is present, force a release on that edge.
  - timeout=1 for exactly the following cycle; ptr advances as in a normal release.
- Undefined: no counter is built; timeout is tied to 0; a grant is held indefinitely until done or the req drop.

Test Plan:
- Reset check: assert rst_n=0 mid-BUSY -> grant=0000, grant_valid=0 immediately. Release rst_n with req=0 -> outputs stay 0 and state stays IDLE.
- Single request: req=0100 at edge 0 -> after edge 1 grant=0100, grant_idx=10, grant_valid=1. done pulse -> next edge grant=0000 and ptr=3.
- Rotation: hold req=1111, pulse done 2 cycles after each grant -> grant_idx sequence 00,01,10,11,00, with exactly one idle cycle between grants.
- Pointer wrap/skip: after line 1 releases (ptr=2), apply req=0011 -> grant=0001 (line 0), not line 1.
- Request drop: line 3 granted, deassert req[3] with no done -> grant=0000 on the next edge, then line 0 is granted if req[0]=1.
- Timeout (RR_ARB_TIMEOUT_EN, HOLD_MAX=4): hold req=0010 and never pulse done -> release after 4 BUSY cycles with a 1-cycle timeout pulse, then re-grant to line 1 after one idle cycle. Without the macro: grant held for 100 cycles and timeout stays 0.

Source files
------------

// File: rtl/rr_arbiter_4_if.sv
// rtl/rr_arbiter_4_if.sv - request/grant bundle between four clients and the round-robin arbiter
interface rr_arbiter_4_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  // Client side: raises requests and the release pulse, observes the grant.
  modport master (
    output req,
    output done,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  timeout
  );

  // Arbiter side.
  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_idx,
    output grant_valid,
    output timeout
  );
endinterface

// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - four-way round-robin arbiter with hold-until-release grant; optional forced release under RR_ARB_TIMEOUT_EN
module rr_arbiter_4 #(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter_4_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_q;
  logic [1:0] ptr_q;
  logic [3:0] grant_q;
  logic [1:0] grant_idx_q;
  logic       grant_valid_q;

  logic       found_d;
  logic [1:0] win_d;
  logic [1:0] cand;
  logic       rel_normal;
  logic       rel_timeout;

  // Winner search: first requesting line starting at ptr and walking upward mod 4.
  always_comb begin
    found_d = 1'b0;
    win_d   = ptr_q;
    cand    = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!found_d && bus.req[cand]) begin
        found_d = 1'b1;
        win_d   = cand;
      end
    end
  end

  // A done pulse or the owner dropping its request both end the tenure.
  assign rel_normal = bus.done || !bus.req[grant_idx_q];

`ifdef RR_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt_q;
  logic             timeout_q;

  // Forced release only fires when nothing else is releasing, so done always wins.
  assign rel_timeout = !rel_normal && (hold_cnt_q == CNT_W'(HOLD_MAX - 1));
  assign bus.timeout = timeout_q;
`else
  logic [CNT_W-1:0] unused_hold_cfg;

  assign unused_hold_cfg = CNT_W'(HOLD_MAX);
  assign rel_timeout     = 1'b0;
  assign bus.timeout     = 1'b0;
`endif

  // Arbitration FSM with registered grant outputs and pointer bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= 2'b00;
      grant_q       <= 4'b0000;
      grant_idx_q   <= 2'b00;
      grant_valid_q <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt_q    <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
`ifdef RR_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (found_d) begin
            state_q       <= BUSY;
            grant_q       <= 4'b0001 << win_d;
            grant_idx_q   <= win_d;
            grant_valid_q <= 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt_q    <= '0;
`endif
          end
        end
        BUSY: begin
          if (rel_normal || rel_timeout) begin
            state_q       <= IDLE;
            grant_q       <= 4'b0000;
            grant_valid_q <= 1'b0;
            ptr_q         <= grant_idx_q + 2'd1;
`ifdef RR_ARB_TIMEOUT_EN
            timeout_q     <= rel_timeout;
`endif
          end else begin
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt_q    <= hold_cnt_q + 1'b1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.grant_valid = grant_valid_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb/tb_rr_arbiter_4.sv - directed bench for rr_arbiter_4 with a cycle-level reference model
module tb_rr_arbiter_4;

`ifdef RR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
  localparam int HOLD  = 4;
`else
  localparam bit TO_EN = 1'b0;
  localparam int HOLD  = 15;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  rr_arbiter_4_if bus ();

  rr_arbiter_4 #(.HOLD_MAX(HOLD), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: owner is -1 when nobody holds the resource.
  int m_owner   = -1;
  int m_ptr     = 0;
  int m_idx     = 0;
  int m_busy    = 0;
  bit m_timeout = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner   = -1;
      m_ptr     = 0;
      m_idx     = 0;
      m_busy    = 0;
      m_timeout = 1'b0;
    end else begin
      m_timeout = 1'b0;
      if (m_owner < 0) begin
        for (int k = 0; k < 4; k++) begin
          if (m_owner < 0 && bus.req[(m_ptr + k) % 4]) begin
            m_owner = (m_ptr + k) % 4;
            m_idx   = m_owner;
            m_busy  = 1;
          end
        end
      end else begin
        if (bus.done || !bus.req[m_owner]) begin
          m_ptr   = (m_owner + 1) % 4;
          m_owner = -1;
        end else if (TO_EN && m_busy == HOLD) begin
          m_ptr     = (m_owner + 1) % 4;
          m_owner   = -1;
          m_timeout = 1'b1;
        end else begin
          m_busy = m_busy + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Every cycle out of reset the DUT must match the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("model.grant", int'(bus.grant), (m_owner < 0) ? 0 : (1 << m_owner));
      chk("model.grant_valid", int'(bus.grant_valid), (m_owner < 0) ? 0 : 1);
      chk("model.grant_idx", int'(bus.grant_idx), m_idx);
      chk("model.timeout", int'(bus.timeout), int'(m_timeout));
    end
  end

  initial begin
    bus.req  = 4'b0000;
    bus.done = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset.grant", int'(bus.grant), 0);
    chk("reset.grant_valid", int'(bus.grant_valid), 0);
    chk("reset.grant_idx", int'(bus.grant_idx), 0);
    chk("reset.timeout", int'(bus.timeout), 0);
    rst_n = 1'b1;

    // Rotation with all four lines requesting: 0,1,2,3,0 with one idle cycle each
    @(negedge clk);
    bus.req = 4'b1111;
    @(negedge clk);
    for (int g = 0; g < 5; g++) begin
      chk("rot.grant_idx", int'(bus.grant_idx), g % 4);
      chk("rot.grant", int'(bus.grant), 1 << (g % 4));
      @(negedge clk);
      bus.done = 1'b1;
      @(negedge clk);
      bus.done = 1'b0;
      chk("rot.idle_gap", int'(bus.grant_valid), 0);
      @(negedge clk);
    end
    chk("rot.next_line1", int'(bus.grant), 4'b0010);

    // Line 1 drops its request -> ptr=2, then 0011 must pick line 0
    bus.req = 4'b0000;
    @(negedge clk);
    chk("drop1.valid", int'(bus.grant_valid), 0);
    chk("drop1.ptr", m_ptr, 2);
    bus.req = 4'b0011;
    @(negedge clk);
    chk("skip.grant", int'(bus.grant), 4'b0001);
    chk("skip.idx", int'(bus.grant_idx), 0);
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;

    // ptr=1: 1001 grants line 3; dropping req[3] releases, then line 0 wins
    bus.req = 4'b1001;
    @(negedge clk);
    chk("drop3.grant", int'(bus.grant), 4'b1000);
    chk("drop3.idx", int'(bus.grant_idx), 3);
    bus.req = 4'b0001;
    @(negedge clk);
    chk("drop3.release", int'(bus.grant), 0);
    @(negedge clk);
    chk("drop3.line0", int'(bus.grant), 4'b0001);
    bus.done = 1'b1;
    bus.req  = 4'b0000;
    @(negedge clk);
    bus.done = 1'b0;

    // Single request on line 2, released by done -> ptr=3, idx held
    bus.req = 4'b0100;
    @(negedge clk);
    chk("single.grant", int'(bus.grant), 4'b0100);
    chk("single.idx", int'(bus.grant_idx), 2);
    chk("single.valid", int'(bus.grant_valid), 1);
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    bus.req  = 4'b0000;
    chk("single.release", int'(bus.grant), 0);
    chk("single.idx_hold", int'(bus.grant_idx), 2);
    chk("single.ptr", m_ptr, 3);

    // Done and request drop together count as one release
    bus.req = 4'b0100;
    @(negedge clk);
    bus.req  = 4'b0000;
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    chk("both.release", int'(bus.grant_valid), 0);
    chk("both.ptr", m_ptr, 3);
    @(negedge clk);

    // Long hold on line 1 with no done
    bus.req = 4'b0010;
    @(negedge clk);
    chk("hold.grant", int'(bus.grant), 4'b0010);
    if (TO_EN) begin
      repeat (3) @(negedge clk);
      chk("to.still_busy", int'(bus.grant_valid), 1);
      @(negedge clk);
      chk("to.release", int'(bus.grant_valid), 0);
      chk("to.pulse", int'(bus.timeout), 1);
      @(negedge clk);
      chk("to.regrant", int'(bus.grant), 4'b0010);
      chk("to.pulse_end", int'(bus.timeout), 0);
    end else begin
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        chk("hold.valid", int'(bus.grant_valid), 1);
        chk("hold.timeout", int'(bus.timeout), 0);
      end
    end

    // Asynchronous reset mid-tenure drops the grant immediately
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst.grant", int'(bus.grant), 0);
    chk("rst.valid", int'(bus.grant_valid), 0);
    bus.req = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.idle_grant", int'(bus.grant), 0);
    chk("rst.idle_valid", int'(bus.grant_valid), 0);
    chk("rst.ptr", m_ptr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
